// File: rtl/rf_pulse_rx_framer_pkg.sv
// Shared types and defaults for the pulse-position RX framer and its window tracker.
package rf_pulse_rx_framer_pkg;

    localparam int PACKET_SIZE_DEF = 24;
    localparam int PRE_LEN_DEF     = 8;
    localparam int CNT_W_DEF       = 16;
    localparam int BYTES_DEF       = PACKET_SIZE_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_pulse_rx_framer_window.sv
// Bit-window recovery: synchronises rfin, detects pulse edges and tracks one
// window per count_val clocks, re-centred on each first pulse in a window.
module rf_pulse_rx_framer_window #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rfin_i,
    input  logic [CNT_W-1:0] count_val_i,
    input  logic             start_i,
    input  logic             run_i,
    output logic             pulse_edge_o,
    output logic             bit_valid_o,
    output logic             bit_val_o
);

    logic [2:0]       sync_q;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] half;
    logic             win_end;

    assign half         = count_val_i >> 1;
    assign pulse_edge_o = sync_q[1] & ~sync_q[2];
    assign win_end      = run_i && (win_cnt_q == count_val_i - CNT_W'(1));
    assign bit_valid_o  = win_end;
    assign bit_val_o    = seen_q;

    always_comb begin
        // NOTE: defaults first so every path assigns each _d, otherwise a latch is inferred.
        win_cnt_d = win_cnt_q;
        seen_d    = seen_q;
        if (start_i) begin
            win_cnt_d = half;
            seen_d    = 1'b1;
        end else if (!run_i) begin
            win_cnt_d = '0;
            seen_d    = 1'b0;
        end else if (win_end) begin
            // A pulse landing on the boundary opens the next window already seen.
            win_cnt_d = pulse_edge_o ? half : '0;
            seen_d    = pulse_edge_o;
        end else if (pulse_edge_o && !seen_q) begin
            win_cnt_d = half;
            seen_d    = 1'b1;
        end else begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            win_cnt_q <= '0;
            seen_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], rfin_i};
            win_cnt_q <= win_cnt_d;
            seen_q    <= seen_d;
        end
    end

endmodule

// File: rtl/rf_pulse_rx_framer.sv
// Pulse-position RX framer: locks on an all-ones preamble, assembles the payload
// and serves it MSB-byte-first to the SPI readout path.
module rf_pulse_rx_framer
    import rf_pulse_rx_framer_pkg::*;
#(
    parameter int PACKET_SIZE = PACKET_SIZE_DEF,
    parameter int PRE_LEN     = PRE_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_en_i,
    input  logic                   rfin_i,
    input  logic [CNT_W-1:0]       count_val_i,
    input  logic                   byte_rd_i,
    input  logic                   clr_ovr_i,
    output logic                   pkt_rec_o,
    output logic [PACKET_SIZE-1:0] pkt_data_o,
    output logic [7:0]             byte_out_o,
    output logic                   overrun_o,
    output logic                   rx_busy_o
);

    localparam int BYTES = PACKET_SIZE / 8;
    localparam int IDX_W = idx_width(BYTES);
    localparam int PRE_W = idx_width(PRE_LEN);
    localparam int BIT_W = idx_width(PACKET_SIZE);

    state_e                 state_q;
    logic [PRE_W-1:0]       pre_cnt_q;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic [PACKET_SIZE-1:0] shreg_q;
    logic [PACKET_SIZE-1:0] pkt_data_q;
    logic                   pkt_rec_q;
    logic [IDX_W-1:0]       rd_idx_q;
    logic                   overrun_q;

    logic enable, start, run, done;
    logic pulse_edge, bit_valid, bit_val;

    // Windows shorter than 4 clocks cannot hold a centred pulse, so treat them as disabled.
    assign enable = rx_en_i && (count_val_i >= CNT_W'(4));
    assign start  = enable && (state_q == ST_IDLE) && pulse_edge;
    assign run    = enable && ((state_q == ST_PRE) || (state_q == ST_PAY));
    assign done   = enable && (state_q == ST_DONE);

    rf_pulse_rx_framer_window #(
        .CNT_W (CNT_W)
    ) u_window (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rfin_i       (rfin_i),
        .count_val_i  (count_val_i),
        .start_i      (start),
        .run_i        (run),
        .pulse_edge_o (pulse_edge),
        .bit_valid_o  (bit_valid),
        .bit_val_o    (bit_val)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            pkt_data_q <= '0;
            pkt_rec_q  <= 1'b0;
            rd_idx_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (!enable) begin
                state_q   <= ST_IDLE;
                pre_cnt_q <= '0;
                bit_cnt_q <= '0;
                shreg_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: if (pulse_edge) begin
                        state_q   <= ST_PRE;
                        pre_cnt_q <= '0;
                    end
                    ST_PRE: if (bit_valid) begin
                        if (!bit_val) begin
                            state_q <= ST_IDLE;
                        end else if (pre_cnt_q == PRE_W'(PRE_LEN - 1)) begin
                            state_q   <= ST_PAY;
                            bit_cnt_q <= '0;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
                        end
                    end
                    ST_PAY: if (bit_valid) begin
                        shreg_q   <= {shreg_q[PACKET_SIZE-2:0], bit_val};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(PACKET_SIZE - 1)) state_q <= ST_DONE;
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end

            // Publishing a new packet takes priority over a same-cycle read.
            if (done) begin
                pkt_data_q <= shreg_q;
                pkt_rec_q  <= 1'b1;
                rd_idx_q   <= '0;
            end else if (byte_rd_i && pkt_rec_q) begin
                if (rd_idx_q == IDX_W'(BYTES - 1)) begin
                    pkt_rec_q <= 1'b0;
                    rd_idx_q  <= '0;
                end else begin
                    rd_idx_q <= rd_idx_q + IDX_W'(1);
                end
            end

            if (done && pkt_rec_q) overrun_q <= 1'b1;
            else if (clr_ovr_i)    overrun_q <= 1'b0;
        end
    end

    always_comb begin
        byte_out_o = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (rd_idx_q == IDX_W'(i)) byte_out_o = pkt_data_q[PACKET_SIZE-1-8*i -: 8];
        end
    end

    assign pkt_rec_o  = pkt_rec_q;
    assign pkt_data_o = pkt_data_q;
    assign overrun_o  = overrun_q;
    assign rx_busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf_pulse_rx_framer.sv
// Bench for rf_pulse_rx_framer: pulse streams built from bit lists, checked
// against a bit-level framing model and a simple readout/overrun model.
module tb_rf_pulse_rx_framer;

    localparam int PS  = 24;
    localparam int NB  = PS / 8;
    localparam int PRE = 8;

    logic        clk = 1'b0;
    logic        rst_n, rx_en, rfin, byte_rd, clr_ovr;
    logic [15:0] count_val;
    logic        pkt_rec, overrun, rx_busy;
    logic [23:0] pkt_data;
    logic [7:0]  byte_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cv = 20;
    int first_n = -1;
    int rise_cyc = -1;
    int rise_cnt = 0;
    bit rec_prev = 1'b0;
    bit busy_seen = 1'b0;

    logic [23:0] m_data;
    bit          m_rec, m_ovr;
    int          m_idx;

    rf_pulse_rx_framer #(.PACKET_SIZE(PS), .PRE_LEN(PRE), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_en_i(rx_en), .rfin_i(rfin),
        .count_val_i(count_val), .byte_rd_i(byte_rd), .clr_ovr_i(clr_ovr),
        .pkt_rec_o(pkt_rec), .pkt_data_o(pkt_data), .byte_out_o(byte_out),
        .overrun_o(overrun), .rx_busy_o(rx_busy)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pkt_rec && !rec_prev) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        rec_prev = pkt_rec;
        if (rx_busy) busy_seen = 1'b1;
    end

    function automatic void model_reset();
        m_data = '0; m_rec = 1'b0; m_ovr = 1'b0; m_idx = 0;
    endfunction

    function automatic void model_publish(input logic [23:0] p);
        if (m_rec) m_ovr = 1'b1;
        m_data = p; m_rec = 1'b1; m_idx = 0;
    endfunction

    // Eight consecutive '1' windows followed by PS windows form a packet; any '0' restarts the hunt.
    function automatic void model_stream(input logic [63:0] v, input int n);
        int run = 0;
        int i = 0;
        while (i < n) begin
            if (run == PRE) begin
                if (i + PS <= n) model_publish(v[n-1-i -: PS]);
                i += PS;
                run = 0;
            end else begin
                run = v[n-1-i] ? run + 1 : 0;
                i++;
            end
        end
    endfunction

    function automatic void model_read();
        if (m_rec) begin
            m_idx++;
            if (m_idx == NB) begin m_rec = 1'b0; m_idx = 0; end
        end
    endfunction

    function automatic logic [7:0] model_byte();
        return m_data[PS-1-8*m_idx -: 8];
    endfunction

    // act: 0 none, 1 drop rx_en at window act_at, 2 async reset at window act_at.
    task automatic send_stream(input logic [63:0] v, input int n, input int jit,
                               input int act_at, input int act);
        int len;
        first_n = -1;
        for (int k = 0; k < n; k++) begin
            len = cv;
            if (jit > 0) len = cv + int'($urandom_range(2 * jit)) - jit;
            @(negedge clk);
            rfin = v[n-1-k];
            if (k == 0) first_n = cyc + 1;
            if (k == act_at && act == 1) begin
                n_cmp++;
                if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL busy_before_drop: got %b want 1", rx_busy); end
                rx_en = 1'b0;
            end
            if (k == act_at && act == 2) begin
                #20 rst_n = 1'b0;
                #1;
                model_reset();
                n_cmp++;
                if ({pkt_rec, pkt_data, byte_out, overrun, rx_busy} !== 35'd0) begin
                    n_bad++;
                    $display("FAIL async_reset: got rec=%b data=%h byte=%h ovr=%b busy=%b want all 0",
                             pkt_rec, pkt_data, byte_out, overrun, rx_busy);
                end
            end
            @(negedge clk);
            rfin = 1'b0;
            if (k == act_at && act == 1) begin
                n_cmp++;
                if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_drop: got %b want 0", rx_busy); end
            end
            repeat (len - 2) @(negedge clk);
        end
        repeat (cv + 8) @(negedge clk);
    endtask

    task automatic read_all(input string tag);
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            n_cmp++;
            if (byte_out !== model_byte() || pkt_rec !== 1'b1) begin
                n_bad++;
                $display("FAIL %s_byte%0d: got byte=%h rec=%b want byte=%h rec=1", tag, b, byte_out, pkt_rec, model_byte());
            end
            byte_rd = 1'b1;
            @(negedge clk);
            byte_rd = 1'b0;
            model_read();
        end
        n_cmp++;
        if (pkt_rec !== m_rec) begin n_bad++; $display("FAIL %s_rec_after: got %b want %b", tag, pkt_rec, m_rec); end
    endtask

    task automatic clear_overrun();
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        m_ovr = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL clr_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_en = 1'b1; rfin = 1'b0; byte_rd = 1'b0; clr_ovr = 1'b0;
        cv = 20; count_val = 16'(cv);
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pkt_rec, pkt_data, byte_out, overrun, rx_busy} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_state: got rec=%b data=%h byte=%h ovr=%b busy=%b want all 0",
                     pkt_rec, pkt_data, byte_out, overrun, rx_busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [63:0] v;
        int exp_rise;
        v = 64'({8'hFF, 24'hA5C3F0});
        rise_cyc = -1;
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        exp_rise = first_n + 3 + cv - cv / 2 + 31 * cv;
        n_cmp++;
        if (rise_cyc !== exp_rise) begin n_bad++; $display("FAIL t1_rise_cycle: got %0d want %0d", rise_cyc, exp_rise); end
        n_cmp++;
        if (pkt_data !== m_data || pkt_rec !== 1'b1) begin
            n_bad++; $display("FAIL t1_data: got %h rec=%b want %h rec=1", pkt_data, pkt_rec, m_data);
        end
        read_all("t1");
        @(negedge clk); byte_rd = 1'b1;
        @(negedge clk); byte_rd = 1'b0;
        n_cmp++;
        if (pkt_rec !== 1'b0 || byte_out !== m_data[23:16]) begin
            n_bad++; $display("FAIL idle_read: got rec=%b byte=%h want rec=0 byte=%h", pkt_rec, byte_out, m_data[23:16]);
        end
    endtask

    task automatic test_broken_preamble();
        logic [63:0] v;
        int rises;
        v = 64'({6'b111110, 8'hFF, 24'h123456});
        rises = rise_cnt;
        send_stream(v, 38, 0, -1, 0);
        model_stream(v, 38);
        n_cmp++;
        if (rise_cnt - rises !== 1) begin n_bad++; $display("FAIL t2_packet_count: got %0d want 1", rise_cnt - rises); end
        n_cmp++;
        if (pkt_data !== m_data) begin n_bad++; $display("FAIL t2_data: got %h want %h", pkt_data, m_data); end
        read_all("t2");
    endtask

    task automatic test_jitter();
        logic [63:0] v;
        cv = 40; count_val = 16'(cv);
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 2, -1, 0);
        model_stream(v, 32);
        n_cmp++;
        if (pkt_data !== m_data || pkt_rec !== m_rec) begin
            n_bad++; $display("FAIL t3_jitter: got %h rec=%b want %h rec=%b", pkt_data, pkt_rec, m_data, m_rec);
        end
        read_all("t3");
        cv = 20; count_val = 16'(cv);
    endtask

    task automatic test_overrun();
        logic [63:0] v;
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        v = 64'({8'hFF, 24'h00FFFF});
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        n_cmp++;
        if (overrun !== m_ovr || pkt_data !== m_data || byte_out !== model_byte()) begin
            n_bad++;
            $display("FAIL t4_overrun: got ovr=%b data=%h byte=%h want ovr=%b data=%h byte=%h",
                     overrun, pkt_data, byte_out, m_ovr, m_data, model_byte());
        end
        clear_overrun();
        read_all("t4");
    endtask

    task automatic test_done_vs_read();
        logic [63:0] v;
        bit hit;
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        @(negedge clk); byte_rd = 1'b1;
        @(negedge clk); byte_rd = 1'b0;
        model_read();
        v = 64'({8'hFF, 24'($urandom)});
        hit = 1'b0;
        first_n = -1;
        fork
            send_stream(v, 32, 0, -1, 0);
            begin
                for (int t = 0; t < 64 * cv; t++) begin
                    @(negedge clk);
                    if (first_n > 0 && cyc == first_n + 2 + cv - cv / 2 + 31 * cv) begin
                        byte_rd = 1'b1;
                        @(negedge clk);
                        byte_rd = 1'b0;
                        hit = 1'b1;
                        break;
                    end
                end
            end
        join
        model_stream(v, 32);
        n_cmp++;
        if (hit !== 1'b1) begin n_bad++; $display("FAIL collide_timeout: got %b want 1", hit); end
        n_cmp++;
        if (pkt_rec !== 1'b1 || byte_out !== model_byte() || overrun !== m_ovr) begin
            n_bad++;
            $display("FAIL collide: got rec=%b byte=%h ovr=%b want rec=1 byte=%h ovr=%b",
                     pkt_rec, byte_out, overrun, model_byte(), m_ovr);
        end
        clear_overrun();
        read_all("collide");
    endtask

    task automatic test_rx_en_drop();
        logic [63:0] v;
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 0, PRE + 10, 1);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (pkt_data !== m_data || pkt_rec !== m_rec || rx_busy !== 1'b0) begin
            n_bad++; $display("FAIL t5_held: got %h rec=%b busy=%b want %h rec=%b busy=0", pkt_data, pkt_rec, rx_busy, m_data, m_rec);
        end
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        n_cmp++;
        if (pkt_data !== m_data || overrun !== m_ovr) begin
            n_bad++; $display("FAIL t5_rerun: got %h ovr=%b want %h ovr=%b", pkt_data, overrun, m_data, m_ovr);
        end
        clear_overrun();
        read_all("t5");
    endtask

    task automatic test_random();
        logic [63:0] v;
        int rises;
        int exp_rise;
        for (int r = 0; r < 4; r++) begin
            cv = int'($urandom_range(32, 8)); count_val = 16'(cv);
            v = 64'({3'($urandom), 1'b0, 8'hFF, 24'($urandom)});
            rises = rise_cnt;
            send_stream(v, 36, 0, -1, 0);
            model_stream(v, 36);
            exp_rise = first_n + 4 * cv + 3 + cv - cv / 2 + 31 * cv;
            n_cmp++;
            if (rise_cnt - rises !== 1 || rise_cyc !== exp_rise) begin
                n_bad++; $display("FAIL rand%0d_rise: got n=%0d cyc=%0d want n=1 cyc=%0d", r, rise_cnt - rises, rise_cyc, exp_rise);
            end
            n_cmp++;
            if (pkt_data !== m_data) begin n_bad++; $display("FAIL rand%0d_data: got %h want %h", r, pkt_data, m_data); end
            read_all("rand");
        end
        cv = 20; count_val = 16'(cv);
    endtask

    task automatic test_async_reset_and_short_window();
        logic [63:0] v;
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 0, PRE + 7, 2);
        @(negedge clk); rst_n = 1'b1;
        cv = 3; count_val = 16'(cv);
        busy_seen = 1'b0;
        v = 64'({8'hFF, 24'($urandom)});
        send_stream(v, 32, 0, -1, 0);
        n_cmp++;
        if (busy_seen !== 1'b0 || pkt_rec !== 1'b0) begin
            n_bad++; $display("FAIL t6_short_window: got busy_seen=%b rec=%b want 0 0", busy_seen, pkt_rec);
        end
        cv = 20; count_val = 16'(cv);
        send_stream(v, 32, 0, -1, 0);
        model_stream(v, 32);
        n_cmp++;
        if (pkt_data !== m_data || pkt_rec !== 1'b1) begin
            n_bad++; $display("FAIL t6_recover: got %h rec=%b want %h rec=1", pkt_data, pkt_rec, m_data);
        end
        read_all("t6");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_broken_preamble();
        test_jitter();
        test_overrun();
        test_done_vs_read();
        test_rx_en_drop();
        test_random();
        test_async_reset_and_short_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
